// File: rtl/game_pkg.sv
// Shared definitions for the memory-sequence game controller: state codes,
// datapath command-strobe positions and the strobe decode.
package game_pkg;

  localparam int unsigned TICK_HZ = 1;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_INIT       = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP      = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY_FPGA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PLAY_USER  = 3'd3;
  localparam logic [STATE_W-1:0] ST_CHECK      = 3'd4;
  localparam logic [STATE_W-1:0] ST_NEXT_ROUND = 3'd5;
  localparam logic [STATE_W-1:0] ST_RESULT     = 3'd6;
  localparam logic [STATE_W-1:0] ST_RETRY      = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    S_INIT       = ST_INIT,
    S_SETUP      = ST_SETUP,
    S_PLAY_FPGA  = ST_PLAY_FPGA,
    S_PLAY_USER  = ST_PLAY_USER,
    S_CHECK      = ST_CHECK,
    S_NEXT_ROUND = ST_NEXT_ROUND,
    S_RESULT     = ST_RESULT,
    S_RETRY      = ST_RETRY
  } state_t;

  localparam int unsigned CMD_R1  = 0;
  localparam int unsigned CMD_R2  = 1;
  localparam int unsigned CMD_E1  = 2;
  localparam int unsigned CMD_E2  = 3;
  localparam int unsigned CMD_E3  = 4;
  localparam int unsigned CMD_E4  = 5;
  localparam int unsigned CMD_SEL = 6;
  localparam int unsigned CMD_W   = 7;

  // Moore strobe decode: exactly the commands each phase issues to the datapath.
  function automatic logic [CMD_W-1:0] cmd_decode(input state_t s);
    logic [CMD_W-1:0] c;
    c = '0;
    case (s)
      S_INIT:       begin c[CMD_R1] = 1'b1; c[CMD_R2] = 1'b1; end
      S_SETUP:      c[CMD_E1]  = 1'b1;
      S_PLAY_FPGA:  c[CMD_E3]  = 1'b1;
      S_PLAY_USER:  c[CMD_E2]  = 1'b1;
      S_CHECK:      c[CMD_E4]  = 1'b1;
      S_NEXT_ROUND: c[CMD_R2]  = 1'b1;
      S_RETRY:      c[CMD_R2]  = 1'b1;
      S_RESULT:     c[CMD_SEL] = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/game_turn_timer.sv
// Per-turn seconds counter: counts tick pulses while enabled, saturates at
// LIMIT and flags expiry.
module game_turn_timer #(
  parameter int unsigned LIMIT = 9,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expired_c
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && tick && (count < W'(LIMIT)))
      count <= count + W'(1);
  end

  assign expired_c = (count == W'(LIMIT));

endmodule

// File: rtl/game_control_multi.sv
// Game controller FSM for the memory-sequence game with round counting,
// win detection, per-turn timeout and a retry budget.
module game_control_multi
  import game_pkg::*;
#(
  parameter int unsigned N_ROUNDS    = 16,
  parameter int unsigned TIME_LIMIT  = 9 * TICK_HZ,
  parameter int unsigned MAX_RETRIES = 0,
  parameter int unsigned ROUND_W     = $clog2(N_ROUNDS + 1),
  parameter int unsigned TIME_W      = $clog2(TIME_LIMIT + 1),
  parameter int unsigned RETRY_W     = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter,
  input  logic               end_fpga,
  input  logic               end_user,
  input  logic               match,
  input  logic               tick_1hz,
  output logic               r1,
  output logic               r2,
  output logic               e1,
  output logic               e2,
  output logic               e3,
  output logic               e4,
  output logic               sel,
  output logic [ROUND_W-1:0] round,
  output logic [TIME_W-1:0]  time_cnt,
  output logic [RETRY_W-1:0] retries_left,
  output logic               user_won,
  output logic [2:0]         state_o
);

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               won_q, won_d;
  logic               enter_q;
  logic               enter_rise_c;
  logic               timer_clear_c;
  logic               timer_en_c;
  logic               timeout_c;
  logic [CMD_W-1:0]   cmd_c;

  assign enter_rise_c  = enter & ~enter_q;
  assign timer_clear_c = (state_q == S_INIT) || ((state_q == S_PLAY_FPGA) && end_fpga);
  assign timer_en_c    = (state_q == S_PLAY_USER);

  game_turn_timer #(
    .LIMIT (TIME_LIMIT),
    .W     (TIME_W)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (timer_clear_c),
    .enable    (timer_en_c),
    .tick      (tick_1hz),
    .count     (time_cnt),
    .expired_c (timeout_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      round_q   <= '0;
      retries_q <= RETRY_W'(MAX_RETRIES);
      won_q     <= 1'b0;
      enter_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      retries_q <= retries_d;
      won_q     <= won_d;
      enter_q   <= enter;
    end
  end

  // Next-state and game-bookkeeping updates.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    retries_d = retries_q;
    won_d     = won_q;
    case (state_q)
      S_INIT: begin
        round_d   = '0;
        retries_d = RETRY_W'(MAX_RETRIES);
        won_d     = 1'b0;
        state_d   = S_SETUP;
      end
      S_SETUP:
        if (enter_rise_c) state_d = S_PLAY_FPGA;
      S_PLAY_FPGA:
        if (end_fpga) state_d = S_PLAY_USER;
      S_PLAY_USER: begin
        // Timeout takes priority over a simultaneous end_user.
        if (timeout_c) begin
          won_d   = 1'b0;
          state_d = S_RESULT;
        end else if (end_user) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (match) begin
          if (round_q < ROUND_W'(N_ROUNDS)) round_d = round_q + ROUND_W'(1);
          state_d = S_NEXT_ROUND;
        end else if (retries_q != '0) begin
          retries_d = retries_q - RETRY_W'(1);
          state_d   = S_RETRY;
        end else begin
          won_d   = 1'b0;
          state_d = S_RESULT;
        end
      end
      S_NEXT_ROUND: begin
        if (round_q == ROUND_W'(N_ROUNDS)) begin
          won_d   = 1'b1;
          state_d = S_RESULT;
        end else begin
          state_d = S_PLAY_FPGA;
        end
      end
      S_RETRY:
        state_d = S_PLAY_FPGA;
      S_RESULT:
        if (enter_rise_c) state_d = S_INIT;
      default:
        state_d = S_INIT;
    endcase
  end

  assign cmd_c = cmd_decode(state_q);
  assign r1    = cmd_c[CMD_R1];
  assign r2    = cmd_c[CMD_R2];
  assign e1    = cmd_c[CMD_E1];
  assign e2    = cmd_c[CMD_E2];
  assign e3    = cmd_c[CMD_E3];
  assign e4    = cmd_c[CMD_E4];
  assign sel   = cmd_c[CMD_SEL];

  assign round        = round_q;
  assign retries_left = retries_q;
  assign user_won     = won_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_game_control_multi.sv
// Bench for game_control_multi: scripted vector table, hand-written corner
// sequences and randomized play checked against a phase-level game model.
module tb_game_control_multi;

  localparam int unsigned NR = 2;
  localparam int unsigned TL = 3;
  localparam int unsigned MR = 1;
  localparam int unsigned RW = $clog2(NR + 1);
  localparam int unsigned TW = $clog2(TL + 1);
  localparam int unsigned XW = (MR == 0) ? 1 : $clog2(MR + 1);

  localparam int P_INIT = 0, P_SETUP = 1, P_FPGA = 2, P_USER = 3;
  localparam int P_CHECK = 4, P_NEXT = 5, P_RESULT = 6, P_RETRY = 7;

  logic clock = 1'b0;
  logic reset, enter, end_fpga, end_user, match, tick_1hz;
  logic r1, r2, e1, e2, e3, e4, sel, user_won;
  logic [RW-1:0] round;
  logic [TW-1:0] time_cnt;
  logic [XW-1:0] retries_left;
  logic [2:0]    state_o;

  always #5 clock = ~clock;

  game_control_multi #(
    .N_ROUNDS    (NR),
    .TIME_LIMIT  (TL),
    .MAX_RETRIES (MR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enter        (enter),
    .end_fpga     (end_fpga),
    .end_user     (end_user),
    .match        (match),
    .tick_1hz     (tick_1hz),
    .r1           (r1),
    .r2           (r2),
    .e1           (e1),
    .e2           (e2),
    .e3           (e3),
    .e4           (e4),
    .sel          (sel),
    .round        (round),
    .time_cnt     (time_cnt),
    .retries_left (retries_left),
    .user_won     (user_won),
    .state_o      (state_o)
  );

  typedef struct {
    int en, ef, eu, mt, tk;
    int st, rnd, tm, rt, wn;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Game model: phase, rounds won, seconds used, retries remaining, winner.
  int   m_phase, m_round, m_secs, m_ret, m_won;
  logic m_enter_prev;

  function automatic vec_t mk(input int en, ef, eu, mt, tk, st, rnd, tm, rt, wn);
    vec_t v;
    v.en = en; v.ef = ef; v.eu = eu; v.mt = mt; v.tk = tk;
    v.st = st; v.rnd = rnd; v.tm = tm; v.rt = rt; v.wn = wn;
    return v;
  endfunction

  // Strobes as {r1,r2,e1,e2,e3,e4,sel} per phase.
  function automatic int exp_cmd(input int s);
    case (s)
      P_INIT:   return 'b1100000;
      P_SETUP:  return 'b0010000;
      P_FPGA:   return 'b0000100;
      P_USER:   return 'b0001000;
      P_CHECK:  return 'b0000010;
      P_NEXT:   return 'b0100000;
      P_RESULT: return 'b0000001;
      default:  return 'b0100000;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vs(input string tag, input int st, rnd, tm, rt, wn);
    chk({tag, " state"},   int'(state_o), st);
    chk({tag, " round"},   int'(round), rnd);
    chk({tag, " time"},    int'(time_cnt), tm);
    chk({tag, " retries"}, int'(retries_left), rt);
    chk({tag, " won"},     int'(user_won), wn);
    chk({tag, " strobes"}, int'({r1, r2, e1, e2, e3, e4, sel}), exp_cmd(st));
  endtask

  task automatic model_reset();
    m_phase = P_INIT; m_round = 0; m_secs = 0; m_ret = MR; m_won = 0;
    m_enter_prev = 1'b0;
  endtask

  // One clock of game rules applied to the inputs present at that edge.
  task automatic model_step(input logic en, ef, eu, mt, tk);
    bit rise;
    bit out_of_time;
    rise = en && !m_enter_prev;
    m_enter_prev = en;
    out_of_time = (m_secs == int'(TL));
    case (m_phase)
      P_INIT: begin
        m_round = 0; m_secs = 0; m_won = 0; m_ret = MR; m_phase = P_SETUP;
      end
      P_SETUP:  if (rise) m_phase = P_FPGA;
      P_FPGA:   if (ef) begin m_secs = 0; m_phase = P_USER; end
      P_USER: begin
        if (tk && m_secs < int'(TL)) m_secs++;
        if (out_of_time) begin m_won = 0; m_phase = P_RESULT; end
        else if (eu) m_phase = P_CHECK;
      end
      P_CHECK: begin
        if (mt) begin
          m_round = (m_round + 1 > int'(NR)) ? int'(NR) : m_round + 1;
          m_phase = P_NEXT;
        end else if (m_ret > 0) begin
          m_ret--; m_phase = P_RETRY;
        end else begin
          m_won = 0; m_phase = P_RESULT;
        end
      end
      P_NEXT: begin
        if (m_round == int'(NR)) begin m_won = 1; m_phase = P_RESULT; end
        else m_phase = P_FPGA;
      end
      P_RESULT: if (rise) m_phase = P_INIT;
      default:  m_phase = P_FPGA;
    endcase
  endtask

  task automatic step(input logic en, ef, eu, mt, tk, input string tag);
    enter = en; end_fpga = ef; end_user = eu; match = mt; tick_1hz = tk;
    model_step(en, ef, eu, mt, tk);
    @(posedge clock);
    #1;
    check_vs(tag, m_phase, m_round, m_secs, m_ret, m_won);
  endtask

  initial begin
    logic en_l;
    // Scripted game: enter held through reset, win, timeout, retry then loss.
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 3,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,1, 3,0,1,1,0));
    vecs.push_back(mk(0,0,1,0,0, 4,0,1,1,0));
    vecs.push_back(mk(0,0,0,1,0, 5,1,1,1,0));
    vecs.push_back(mk(0,0,0,0,0, 2,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,0, 3,1,0,1,0));
    vecs.push_back(mk(0,0,1,0,0, 4,1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 7,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 2,1,0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 3,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 3,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 3,1,2,0,0));
    vecs.push_back(mk(0,0,0,0,1, 3,1,3,0,0));
    vecs.push_back(mk(0,0,1,0,1, 6,1,3,0,0));
    vecs.push_back(mk(0,0,0,0,0, 6,1,3,0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,1,3,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 3,0,0,1,0));
    vecs.push_back(mk(0,0,1,0,0, 4,0,0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 5,1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 2,1,0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 3,1,0,1,0));
    vecs.push_back(mk(0,0,1,0,0, 4,1,0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 5,2,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 6,2,0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 6,2,0,1,1));
    vecs.push_back(mk(1,0,0,0,0, 0,2,0,1,1));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0, 2,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 3,0,0,1,0));
    vecs.push_back(mk(0,0,1,0,0, 4,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 7,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 2,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 3,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 4,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 6,0,0,0,0));

    reset = 1'b1; enter = 1'b1; end_fpga = 1'b0; end_user = 1'b0;
    match = 1'b0; tick_1hz = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_vs("reset", P_INIT, 0, 0, MR, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en[0], vecs[i].ef[0], vecs[i].eu[0], vecs[i].mt[0], vecs[i].tk[0], "tbl_model");
      check_vs($sformatf("row%0d", i), vecs[i].st, vecs[i].rnd, vecs[i].tm, vecs[i].rt, vecs[i].wn);
    end

    // Async reset in the middle of a user turn, with a round already won.
    step(1,0,0,0,0, "seqA"); step(1,0,0,0,0, "seqA"); step(0,0,0,0,0, "seqA");
    step(1,0,0,0,0, "seqA"); step(0,1,0,0,0, "seqA"); step(0,0,1,0,0, "seqA");
    step(0,0,0,1,0, "seqA"); step(0,0,0,0,0, "seqA"); step(0,1,0,0,0, "seqA");
    step(0,0,0,0,1, "seqA"); step(0,0,0,0,1, "seqA");
    check_vs("pre_arst", P_USER, 1, 2, MR, 0);
    reset = 1'b1;
    #1;
    chk("arst state", int'(state_o), P_INIT);
    chk("arst round", int'(round), 0);
    chk("arst time", int'(time_cnt), 0);
    chk("arst r1r2", int'({r1, r2}), 3);
    model_reset();
    @(posedge clock);
    #1;
    check_vs("arst hold", P_INIT, 0, 0, MR, 0);
    reset = 1'b0;

    // Pure timeout with no end_user.
    step(0,0,0,0,0, "seqB"); step(1,0,0,0,0, "seqB"); step(0,1,0,0,0, "seqB");
    step(0,0,0,0,1, "seqB"); step(0,0,0,0,1, "seqB"); step(0,0,0,0,1, "seqB");
    check_vs("timeout_sat", P_USER, 0, 3, MR, 0);
    step(0,0,0,0,0, "seqB");
    check_vs("timeout", P_RESULT, 0, 3, MR, 0);

    // Randomized play with occasional mid-cycle async resets.
    en_l = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) en_l = ~en_l;
      step(en_l, $urandom_range(2) == 0, $urandom_range(3) == 0,
           $urandom_range(1) == 0, $urandom_range(2) == 0, "rand");
      if ($urandom_range(199) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_vs("rand_arst", m_phase, m_round, m_secs, m_ret, m_won);
        @(posedge clock);
        #1;
        reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_control_multi.md
Name: game_control_multi

Overview:
- Parametrised successor of the game controller FSM for the memory-sequence game (FPGA plays a sequence, user repeats it on KEYs).
- Sequences the phases Init / Setup / Play FPGA / Play User / Check / Next Round / Result, plus a new Retry phase.
- Adds internal round counting, win detection, play-time timeout, a retry budget, enter edge detection and winner reporting.
- Drives the same datapath command strobes (r1, r2, e1..e4, sel) to the counters, sequence ROM and display muxes.

Parameters:
N_ROUNDS, 16, rounds to complete for a user win (1..64)
TIME_LIMIT, 9, 1 Hz ticks allowed per user turn (1..63)
MAX_RETRIES, 0, mismatches forgiven per game; 0 = original single-miss behaviour
ROUND_W, $clog2(N_ROUNDS+1), width of round output (derived)
TIME_W, $clog2(TIME_LIMIT+1), width of time output (derived)
RETRY_W, $clog2(MAX_RETRIES+1) min 1, width of retries output (derived)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; forces INIT and clears all registers
enter  in  1  level from SW[0]; only its rising edge is used
end_fpga  in  1  sequence playback finished
end_user  in  1  user finished entering the sequence
match  in  1  user entry equals the FPGA sequence; valid in CHECK
tick_1hz  in  1  one-clock pulse at 1 Hz
r1  out  1  reset setup registers
r2  out  1  reset sequence and user counters
e1  out  1  enable setup register load
e2  out  1  enable user input / timer
e3  out  1  enable FPGA playback
e4  out  1  enable check / round compare
sel  out  1  display mux selects result screen
round  out  ROUND_W  completed rounds
time_cnt  out  TIME_W  seconds elapsed in the current user turn (HEX2)
retries_left  out  RETRY_W  remaining retries
user_won  out  1  1 = user won, 0 = FPGA won; valid in RESULT
state_o  out  3  current state code, for debug and LEDs

Behaviour:
- State codes: INIT=0, SETUP=1, PLAY_FPGA=2, PLAY_USER=3, CHECK=4, NEXT_ROUND=5, RESULT=6, RETRY=7.
- On reset assertion (async): state=INIT, round=0, time_cnt=0, retries_left=MAX_RETRIES, user_won=0, enter_q=0.
- Command outputs are Moore, decoded from state; all are 0 except:
  - INIT: r1=r2=1
  - SETUP: e1
  - PLAY_FPGA: e3
  - PLAY_USER: e2
  - CHECK: e4
  - NEXT_ROUND: r2
  - RETRY: r2
  - RESULT: sel
- Enter edge: enter_q registers enter each cycle; enter_rise = enter & ~enter_q.
- INIT -> SETUP after 1 cycle. INIT also clears round, time_cnt, user_won and reloads retries_left.
- SETUP -> PLAY_FPGA on enter_rise. An enter level held high through INIT does not start the game.
- PLAY_FPGA -> PLAY_USER when end_fpga=1. time_cnt clears on that transition.
- PLAY_USER:
  - time_cnt increments on tick_1hz and saturates at TIME_LIMIT.
  - Leave to RESULT (user_won=0) the cycle after time_cnt==TIME_LIMIT is observed.
  - Else leave to CHECK if end_user=1.
  - If timeout and end_user occur in the same cycle, timeout wins.
- CHECK (1 cycle):
  - match=1: round increments (saturating at N_ROUNDS) -> NEXT_ROUND.
  - match=0 and retries_left>0: retries_left decrements -> RETRY.
  - match=0 and retries_left==0: user_won=0 -> RESULT.
- NEXT_ROUND (1 cycle): round==N_ROUNDS -> RESULT with user_won=1; else -> PLAY_FPGA.
- RETRY (1 cycle): -> PLAY_FPGA; round is unchanged, so the same round is replayed.
- RESULT: holds; enter_rise -> INIT (soft restart). reset also returns to INIT at any time.
- Unreachable or illegal codes: none exist with 8 states; the default branch -> INIT.
- Reset mid-game: immediate INIT; all strobes drop asynchronously with the state.

Decomposition:
- Shared package game_pkg: state code localparams (3-bit), command-strobe bit positions, and TICK_HZ.
- Sub-module game_turn_timer: counts tick_1hz, supports clear and enable, saturates, and flags expired; instantiated once.
- FSM, round counter and retry counter stay in game_control_multi.

Test Plan:
- Async reset mid PLAY_USER (time_cnt=5) -> state_o=0 without a clock edge; round=0; r1=r2=1 on the next INIT cycle.
- N_ROUNDS=2, match=1 every check -> round goes 1 then 2; user_won=1; state_o=6; sel=1.
- TIME_LIMIT=3, no end_user -> after the 3rd tick, state goes RESULT with user_won=0; time_cnt=3.
- end_user and timeout in the same cycle -> RESULT, not CHECK.
- MAX_RETRIES=1, match=0 twice -> first miss: RETRY, retries_left=0, round unchanged. Second miss: RESULT, user_won=0.
- enter held 1 through reset release -> stays in SETUP; toggling enter 0 -> 1 moves to PLAY_FPGA in 1 cycle; in RESULT, enter_rise -> INIT.
